seq_endpoint_checker: RTL and testbench
=======================================

Name: seq_endpoint_checker

Overview:
- Synthesizable RTL checker that is the hardware counterpart of the stimulus side of our assertion examples.
- Watches single-bit signals a, b, c on one clock.
- Detects the endpoint of the sequence "a ##1 b", the same point at which a .triggered endpoint would fire.
- Then checks that c is high exactly DELAY samples after that endpoint.
- Reports per-attempt pass/fail pulses, saturating counters and a first-failure timestamp, so on-chip or emulation builds get the same verdicts as the SVA property "seq.triggered |-> ##DELAY c".

Parameters:
- DELAY, 1: samples from sequence endpoint to c check; legal range 1..15.
- CNT_W, 8: width of the pass, fail and match counters.
- TS_W, 16: width of the free-running sample counter and the failure timestamp.

Ports:
- clk  in  1  sampling clock; all sampling on posedge.
- rst  in  1  synchronous, active-high reset.
- a  in  1  first sequence term.
- b  in  1  second sequence term, sampled one cycle after a.
- c  in  1  consequent term.
- clr  in  1  synchronous clear of counters, timestamp and first_fail_vld; does not affect the pending attempts.
- trig  out  1  endpoint pulse.
- pass  out  1  attempt-passed pulse.
- fail  out  1  attempt-failed pulse.
- busy  out  1  at least one attempt pending.
- match_cnt  out  CNT_W  endpoints seen (saturating).
- pass_cnt  out  CNT_W  passes (saturating).
- fail_cnt  out  CNT_W  fails (saturating).
- first_fail_vld  out  1  a failure has been captured.
- first_fail_ts  out  TS_W  sample index of the c check of the first failure.

Behaviour:
- Sample n = the values on posedge n.
- ts: free-running TS_W counter, incremented every sample and wrapping. Reset to 0; not cleared by clr.
- a_q: registered a[n-1]. Endpoint at sample n is a_q && b[n], with a_q=0 immediately after reset.
- trig is registered: high for exactly the cycle after sample n when the endpoint holds. Back-to-back endpoints (a=1, b=1 held) give a continuous trig.
- Pending pipeline is a DELAY-bit shift register. Bit 0 is loaded with the endpoint; bits shift every sample.
- When the endpoint from sample n reaches the tail at sample n+DELAY, c[n+DELAY] is evaluated:
  - c=1: pass is high in the following cycle.
  - c=0: fail is high in the following cycle.
- Attempts overlap freely; each endpoint produces exactly one verdict. pass and fail are never high together.
- A new endpoint and a verdict in the same sample are independent and both are processed.
- busy = OR of the pending pipeline bits, registered alongside.
- Counters increment by 1 on the cycle their pulse is emitted and saturate at all-ones with no wrap.
- On the first fail after reset or clr: first_fail_vld=1 and first_fail_ts = ts of the check sample. Later fails do not update it.
- clr takes priority over a same-cycle increment (the counter reads 0 next cycle). A verdict emitted in the same cycle as clr is dropped from the counters; the pulse is still emitted.
- No endpoint ever → no pass and no fail. Vacuous samples are not counted.
- Reset values: trig, pass, fail, busy, first_fail_vld = 0; all counters and first_fail_ts = 0; pipeline and a_q = 0.
- Reset mid-operation discards every pending attempt with no verdict.
- Reset has priority over clr and over all inputs.

Test Plan:
- DELAY=1. Reset samples 0-1; a=1 @ sample 2, b=1 @ 3, c=1 @ 4, all others 0 → trig in cycle after 3; pass in cycle after 4; match_cnt=1, pass_cnt=1, fail_cnt=0.
- DELAY=1, same stimulus but c=0 @ 4 → fail after 4; first_fail_vld=1; first_fail_ts = ts value at sample 4; pass_cnt=0.
- DELAY=3. a=1 @ 2-4, b=1 @ 3-5 (three overlapping endpoints @ 3, 4, 5); c=1 @ 6 and 8, c=0 @ 7 → pass, fail, pass in consecutive cycles; match_cnt=3, pass_cnt=2, fail_cnt=1; busy high from after 3 through after 7.
- DELAY=2. Endpoint @ 5, rst=1 @ 6 → no verdict ever emitted; all outputs 0 after reset; busy=0.
- CNT_W=2. Five passing attempts → pass_cnt saturates at 3. Then clr coinciding with a pass pulse → pass_cnt=0 next cycle, pass pulse still seen.
- a=1 with b=0 the next sample, and b=1 alone with no preceding a → no trig, no verdict; match_cnt stays 0.

Source files
------------

// File: rtl/seq_endpoint_checker.sv
// seq_endpoint_checker
// Hardware equivalent of "seq.triggered |-> ##DELAY c" where seq is "a ##1 b".
// Each endpoint of the sequence starts an attempt that travels down a
// DELAY-deep pending pipeline; when it reaches the tail, c decides pass/fail.
// Verdict pulses feed saturating counters and a first-failure timestamp.
module seq_endpoint_checker #(
    parameter int DELAY = 1,   // samples from endpoint to c check, 1..15
    parameter int CNT_W = 8,   // pass/fail/match counter width
    parameter int TS_W  = 16   // sample counter / timestamp width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clr,
    output logic             trig,
    output logic             pass,
    output logic             fail,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [TS_W-1:0]  first_fail_ts
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        logic [CNT_W-1:0] r;
        r = v;
        if (en && (v != CNT_MAX)) begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic             a_q;        // a from the previous sample
    logic             ep;         // sequence endpoint at the current sample
    logic [DELAY-1:0] pend_p0;    // pending attempts, bit k = endpoint k+1 samples ago
    logic [DELAY-1:0] pend_nxt;
    logic             tail;       // attempt whose c check is this sample
    logic [TS_W-1:0]  ts;         // free-running sample index
    logic [TS_W-1:0]  chk_ts_p1;  // sample index of the check behind the current verdict

    // Endpoint detection and next state of the pending pipeline.
    always_comb begin
        ep          = a_q & b;
        pend_nxt    = '0;
        pend_nxt[0] = ep;
        for (int i = 1; i < DELAY; i++) begin
            pend_nxt[i] = pend_p0[i-1];
        end
        tail = pend_p0[DELAY-1];
    end

    // Stage p0/p1: sample inputs, advance attempts, register endpoint and verdict pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= 1'b0;
            pend_p0 <= '0;
            trig    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            busy    <= 1'b0;
            ts      <= '0;
        end else begin
            a_q     <= a;
            pend_p0 <= pend_nxt;
            trig    <= ep;
            pass    <= tail & c;
            fail    <= tail & ~c;
            busy    <= |pend_nxt;
            ts      <= ts + TS_ONE;
        end
    end

    // Timestamp of the check travels with the verdict pulse; pure data, no reset.
    always_ff @(posedge clk) begin
        chk_ts_p1 <= ts;
    end

    // Stage p2: count the pulses visible this cycle; clr wins over a same-cycle count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            match_cnt      <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_ts  <= '0;
        end else begin
            match_cnt <= sat_inc(match_cnt, trig);
            pass_cnt  <= sat_inc(pass_cnt, pass);
            fail_cnt  <= sat_inc(fail_cnt, fail);
            if (fail && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_ts  <= chk_ts_p1;
            end
        end
    end

endmodule

// File: tb/tb_seq_endpoint_checker.sv
// Bench for seq_endpoint_checker: three instances (DELAY 1/3/2, CNT_W 8/8/2)
// share one stimulus stream and are compared every cycle against a
// queue-based model of the property, plus directed table and sequences.
module tb_seq_endpoint_checker;

    localparam int N = 3;
    localparam int DLY [N] = '{1, 3, 2};
    localparam int CW  [N] = '{8, 8, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, a = 1'b0, b = 1'b0, c = 1'b0, clr = 1'b0;

    logic        o_trig [N];
    logic        o_pass [N];
    logic        o_fail [N];
    logic        o_busy [N];
    logic        o_ffv  [N];
    logic [7:0]  o_mc   [N];
    logic [7:0]  o_pc   [N];
    logic [7:0]  o_fc   [N];
    logic [15:0] o_ts   [N];
    logic [1:0]  mc2, pc2, fc2;

    seq_endpoint_checker #(.DELAY(1), .CNT_W(8), .TS_W(16)) u0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
        .trig(o_trig[0]), .pass(o_pass[0]), .fail(o_fail[0]), .busy(o_busy[0]),
        .match_cnt(o_mc[0]), .pass_cnt(o_pc[0]), .fail_cnt(o_fc[0]),
        .first_fail_vld(o_ffv[0]), .first_fail_ts(o_ts[0]));

    seq_endpoint_checker #(.DELAY(3), .CNT_W(8), .TS_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
        .trig(o_trig[1]), .pass(o_pass[1]), .fail(o_fail[1]), .busy(o_busy[1]),
        .match_cnt(o_mc[1]), .pass_cnt(o_pc[1]), .fail_cnt(o_fc[1]),
        .first_fail_vld(o_ffv[1]), .first_fail_ts(o_ts[1]));

    seq_endpoint_checker #(.DELAY(2), .CNT_W(2), .TS_W(16)) u2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
        .trig(o_trig[2]), .pass(o_pass[2]), .fail(o_fail[2]), .busy(o_busy[2]),
        .match_cnt(mc2), .pass_cnt(pc2), .fail_cnt(fc2),
        .first_fail_vld(o_ffv[2]), .first_fail_ts(o_ts[2]));

    assign o_mc[2] = {6'b0, mc2};
    assign o_pc[2] = {6'b0, pc2};
    assign o_fc[2] = {6'b0, fc2};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each endpoint is an entry holding the sample number of its check.
    logic m_prev_a = 1'b0;
    int   m_abs = 0;
    int   m_ts  = 0;
    logic m_trig [N];
    logic m_pass [N];
    logic m_fail [N];
    logic m_busy [N];
    logic m_ffv  [N];
    int   m_mc [N];
    int   m_pc [N];
    int   m_fc [N];
    int   m_ffts [N];
    int   m_vts [N];
    int   due_q [N][$];

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic model_edge(input int r, input int ia, input int ib, input int ic, input int iclr);
        logic ep, np, nf;
        if (r != 0) begin
            for (int k = 0; k < N; k++) begin
                m_trig[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_busy[k] = 0; m_ffv[k] = 0;
                m_mc[k] = 0; m_pc[k] = 0; m_fc[k] = 0; m_ffts[k] = 0; m_vts[k] = 0;
                due_q[k].delete();
            end
            m_prev_a = 0;
            m_ts = 0;
        end else begin
            ep = m_prev_a && (ib != 0);
            for (int k = 0; k < N; k++) begin
                if (iclr != 0) begin
                    m_mc[k] = 0; m_pc[k] = 0; m_fc[k] = 0; m_ffv[k] = 0; m_ffts[k] = 0;
                end else begin
                    if (m_trig[k]) m_mc[k] = sat(m_mc[k], CW[k]);
                    if (m_pass[k]) m_pc[k] = sat(m_pc[k], CW[k]);
                    if (m_fail[k]) m_fc[k] = sat(m_fc[k], CW[k]);
                    if (m_fail[k] && !m_ffv[k]) begin
                        m_ffv[k]  = 1;
                        m_ffts[k] = m_vts[k];
                    end
                end
                np = 0;
                nf = 0;
                if (due_q[k].size() > 0 && due_q[k][0] == m_abs) begin
                    void'(due_q[k].pop_front());
                    if (ic != 0) np = 1; else nf = 1;
                    m_vts[k] = m_ts;
                end
                if (ep) due_q[k].push_back(m_abs + DLY[k]);
                m_trig[k] = ep;
                m_pass[k] = np;
                m_fail[k] = nf;
                m_busy[k] = (due_q[k].size() > 0);
            end
            m_prev_a = (ia != 0);
            m_ts = (m_ts + 1) % 65536;
            m_abs++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d trig", k), int'(o_trig[k]), int'(m_trig[k]));
            chk($sformatf("u%0d pass", k), int'(o_pass[k]), int'(m_pass[k]));
            chk($sformatf("u%0d fail", k), int'(o_fail[k]), int'(m_fail[k]));
            chk($sformatf("u%0d busy", k), int'(o_busy[k]), int'(m_busy[k]));
            chk($sformatf("u%0d match_cnt", k), int'(o_mc[k]), m_mc[k]);
            chk($sformatf("u%0d pass_cnt", k), int'(o_pc[k]), m_pc[k]);
            chk($sformatf("u%0d fail_cnt", k), int'(o_fc[k]), m_fc[k]);
            chk($sformatf("u%0d first_fail_vld", k), int'(o_ffv[k]), int'(m_ffv[k]));
            chk($sformatf("u%0d first_fail_ts", k), int'(o_ts[k]), m_ffts[k]);
        end
    endtask

    // One sample: drive inputs, let the edge happen, compare on the falling edge.
    task automatic step(input int r, input int ia, input int ib, input int ic, input int iclr);
        rst = (r != 0); a = (ia != 0); b = (ib != 0); c = (ic != 0); clr = (iclr != 0);
        @(posedge clk);
        model_edge(r, ia, ib, ic, iclr);
        @(negedge clk);
        cmp_all();
    endtask

    typedef struct {
        int r, a, b, c, clr;
        int trig, pass, fail, busy, mc, pc, fc, v, ts;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // DELAY=1 instance u0: pass case, fail case, non-matching a/b.
        tbl = '{
            '{1,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{1,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,1,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,0,1,0,0, 1,0,0,1, 0,0,0,0,0},
            '{0,0,0,1,0, 0,1,0,0, 1,0,0,0,0},
            '{0,0,0,0,0, 0,0,0,0, 1,1,0,0,0},
            '{1,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{1,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,1,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,0,1,0,0, 1,0,0,1, 0,0,0,0,0},
            '{0,0,0,0,0, 0,0,1,0, 1,0,0,0,0},
            '{0,0,0,0,0, 0,0,0,0, 1,0,1,1,2},
            '{1,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,1,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,0,1,0,0, 0,0,0,0, 0,0,0,0,0},
            '{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0}
        };
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr);
            chk($sformatf("vec%0d trig", i), int'(o_trig[0]), tbl[i].trig);
            chk($sformatf("vec%0d pass", i), int'(o_pass[0]), tbl[i].pass);
            chk($sformatf("vec%0d fail", i), int'(o_fail[0]), tbl[i].fail);
            chk($sformatf("vec%0d busy", i), int'(o_busy[0]), tbl[i].busy);
            chk($sformatf("vec%0d match_cnt", i), int'(o_mc[0]), tbl[i].mc);
            chk($sformatf("vec%0d pass_cnt", i), int'(o_pc[0]), tbl[i].pc);
            chk($sformatf("vec%0d fail_cnt", i), int'(o_fc[0]), tbl[i].fc);
            chk($sformatf("vec%0d first_fail_vld", i), int'(o_ffv[0]), tbl[i].v);
            chk($sformatf("vec%0d first_fail_ts", i), int'(o_ts[0]), tbl[i].ts);
        end

        // DELAY=3 (u1): three overlapping endpoints at samples 3,4,5.
        step(1,0,0,0,0); step(1,0,0,0,0);
        step(0,1,0,0,0);
        step(0,1,1,0,0);
        chk("ovl trig", int'(o_trig[1]), 1);
        chk("ovl busy first", int'(o_busy[1]), 1);
        step(0,1,1,0,0);
        step(0,0,1,0,0);
        step(0,0,0,1,0);
        chk("ovl pass1", int'(o_pass[1]), 1);
        step(0,0,0,0,0);
        chk("ovl fail", int'(o_fail[1]), 1);
        chk("ovl busy last", int'(o_busy[1]), 1);
        step(0,0,0,1,0);
        chk("ovl pass2", int'(o_pass[1]), 1);
        chk("ovl busy done", int'(o_busy[1]), 0);
        step(0,0,0,0,0); step(0,0,0,0,0);
        chk("ovl match_cnt", int'(o_mc[1]), 3);
        chk("ovl pass_cnt", int'(o_pc[1]), 2);
        chk("ovl fail_cnt", int'(o_fc[1]), 1);

        // DELAY=2 (u2): reset right after an endpoint discards the attempt.
        step(1,0,0,0,0); step(1,0,0,0,0);
        step(0,0,0,0,0); step(0,0,0,0,0);
        step(0,1,0,0,0);
        step(0,0,1,0,0);
        chk("rst trig before", int'(o_trig[2]), 1);
        chk("rst busy before", int'(o_busy[2]), 1);
        step(1,0,0,1,0);
        for (int i = 0; i < 4; i++) begin
            step(0,0,0,(i % 2),0);
            chk($sformatf("rst no pass %0d", i), int'(o_pass[2]), 0);
            chk($sformatf("rst no fail %0d", i), int'(o_fail[2]), 0);
            chk($sformatf("rst busy %0d", i), int'(o_busy[2]), 0);
        end
        chk("rst match_cnt", int'(o_mc[2]), 0);
        chk("rst ffv", int'(o_ffv[2]), 0);

        // CNT_W=2 (u2): five passes saturate pass_cnt, then clr against a pass pulse.
        step(1,0,0,0,0); step(1,0,0,0,0);
        for (int i = 0; i < 6; i++) step(0,1,1,1,0);
        for (int i = 0; i < 3; i++) step(0,0,0,1,0);
        chk("sat pass_cnt", int'(o_pc[2]), 3);
        chk("sat match_cnt", int'(o_mc[2]), 3);
        step(0,1,0,0,0);
        step(0,0,1,0,0);
        step(0,0,0,0,0);
        step(0,0,0,1,0);
        chk("clr pass pulse", int'(o_pass[2]), 1);
        chk("clr pass_cnt held", int'(o_pc[2]), 3);
        step(0,0,0,0,1);
        chk("clr pass_cnt", int'(o_pc[2]), 0);
        step(0,0,0,0,0);
        chk("clr pass_cnt after", int'(o_pc[2]), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 39) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
